// File: rtl/aes_gcm_pkg.sv
// Shared types and constants for the GCM tag verification datapath.
// Bit 0 of every block/length field is the GCM most-significant bit.
package aes_gcm_pkg;

  typedef logic [0:127] block_t;
  typedef logic [0:63]  len_t;

  localparam block_t GCM_R = {8'he1, 120'd0};

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_MULT  = 3'd2;
  localparam logic [2:0] ST_LEN   = 3'd3;
  localparam logic [2:0] ST_FINAL = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_LOAD  = ST_LOAD,
    S_MULT  = ST_MULT,
    S_LEN   = ST_LEN,
    S_FINAL = ST_FINAL,
    S_DONE  = ST_DONE
  } state_e;

  // One GCM "V" step: right shift by index with conditional reduction.
  function automatic block_t gf_shift_v(block_t v);
    return v[127] ? ((v >> 1) ^ GCM_R) : (v >> 1);
  endfunction

  function automatic logic len_misaligned(len_t l);
    return |l[57:63];
  endfunction

endpackage

// File: rtl/gf128_mul_iter.sv
// Iterative GF(2^128) multiplier in GCM bit order; consumes
// MUL_BITS_PER_CYCLE bits of Y per clock, o_done/o_z valid on the last one.
module gf128_mul_iter
  import aes_gcm_pkg::*;
#(
  parameter int unsigned MUL_BITS_PER_CYCLE = 8
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [0:127] i_x,
  input  logic [0:127] i_y,
  output logic         o_done,
  output logic [0:127] o_z
);

  localparam int unsigned N  = 128 / MUL_BITS_PER_CYCLE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  block_t          z_q, v_q, y_q;
  block_t          z_n, v_n;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            last;

  // Next Y bits always sit at the low indices because y_q shifts toward bit 0.
  always_comb begin
    z_n = z_q;
    v_n = v_q;
    for (int unsigned i = 0; i < MUL_BITS_PER_CYCLE; i++) begin
      if (y_q[i]) z_n = z_n ^ v_n;
      v_n = gf_shift_v(v_n);
    end
  end

  assign last   = busy_q && (cnt_q == CW'(N - 1));
  assign o_done = last;
  assign o_z    = z_n;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      z_q    <= '0;
      v_q    <= '0;
      y_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (i_start) begin
      z_q    <= '0;
      v_q    <= i_x;
      y_q    <= i_y;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      z_q   <= z_n;
      v_q   <= v_n;
      y_q   <= y_q << MUL_BITS_PER_CYCLE;
      cnt_q <= cnt_q + 1'b1;
      if (last) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/aes_gcm_tag_verifier.sv
// Receive-side GCM tag check: GHASH over AAD+CT blocks and the length block,
// XOR with E(K,J0), compare against the received tag.
module aes_gcm_tag_verifier
  import aes_gcm_pkg::*;
#(
  parameter int unsigned MUL_BITS_PER_CYCLE = 8
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [0:127] i_h,
  input  logic [0:127] i_encrypted_j0,
  input  logic [0:63]  i_aad_len,
  input  logic [0:63]  i_ct_len,
  input  logic [0:127] i_tag,
  input  logic         i_block_valid,
  input  logic [0:127] i_block,
  output logic         o_block_ready,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_auth_ok,
  output logic         o_len_err,
  output logic [0:127] o_computed_tag
);

  state_e      state_q;
  block_t      s_q, h_q, ej0_q, tag_q, tag_out_q;
  len_t        aad_q, ct_q;
  logic [63:0] total_q, blk_cnt_q, total_d;
  logic        len_done_q, auth_ok_q, len_err_q;

  logic        mul_start, mul_done;
  block_t      mul_x, mul_z, len_blk, final_tag;

  assign total_d   = 64'(i_aad_len >> 7) + 64'(i_ct_len >> 7);
  assign len_blk   = {aad_q, ct_q};
  assign final_tag = s_q ^ ej0_q;

  assign mul_start = ((state_q == S_LOAD) && i_block_valid) || (state_q == S_LEN);
  assign mul_x     = (state_q == S_LEN) ? (s_q ^ len_blk) : (s_q ^ i_block);

  gf128_mul_iter #(
    .MUL_BITS_PER_CYCLE(MUL_BITS_PER_CYCLE)
  ) u_mul (
    .clk    (clk),
    .i_rst_n(i_rst_n),
    .i_start(mul_start),
    .i_x    (mul_x),
    .i_y    (h_q),
    .o_done (mul_done),
    .o_z    (mul_z)
  );

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      s_q        <= '0;
      h_q        <= '0;
      ej0_q      <= '0;
      tag_q      <= '0;
      aad_q      <= '0;
      ct_q       <= '0;
      total_q    <= '0;
      blk_cnt_q  <= '0;
      len_done_q <= 1'b0;
      auth_ok_q  <= 1'b0;
      len_err_q  <= 1'b0;
      tag_out_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            h_q        <= i_h;
            ej0_q      <= i_encrypted_j0;
            tag_q      <= i_tag;
            aad_q      <= i_aad_len;
            ct_q       <= i_ct_len;
            total_q    <= total_d;
            s_q        <= '0;
            blk_cnt_q  <= '0;
            len_done_q <= 1'b0;
            auth_ok_q  <= 1'b0;
            len_err_q  <= 1'b0;
            tag_out_q  <= '0;
            // Length errors pass through FINAL (result suppressed) so the
            // done pulse lands two cycles after start.
            if (len_misaligned(i_aad_len) || len_misaligned(i_ct_len)) begin
              len_err_q <= 1'b1;
              state_q   <= S_FINAL;
            end else if (total_d != 64'd0) begin
              state_q <= S_LOAD;
            end else begin
              state_q <= S_LEN;
            end
          end
        end
        S_LOAD: begin
          if (i_block_valid) begin
            s_q       <= s_q ^ i_block;
            blk_cnt_q <= blk_cnt_q + 64'd1;
            state_q   <= S_MULT;
          end
        end
        S_MULT: begin
          if (mul_done) begin
            s_q <= mul_z;
            if (len_done_q)                state_q <= S_FINAL;
            else if (blk_cnt_q < total_q)  state_q <= S_LOAD;
            else                           state_q <= S_LEN;
          end
        end
        S_LEN: begin
          s_q        <= s_q ^ len_blk;
          len_done_q <= 1'b1;
          state_q    <= S_MULT;
        end
        S_FINAL: begin
          if (!len_err_q) begin
            tag_out_q <= final_tag;
            auth_ok_q <= (final_tag == tag_q);
          end
          state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_block_ready  = (state_q == S_LOAD);
  assign o_busy         = (state_q != S_IDLE);
  assign o_done         = (state_q == S_DONE);
  assign o_auth_ok      = auth_ok_q;
  assign o_len_err      = len_err_q;
  assign o_computed_tag = tag_out_q;

endmodule
